// File: rtl/modexp_seq_ctrl.sv
// Montgomery modexp sequencer: PRE step, one LOOP step per exponent bit, POST step, DONE pulse.
// Done (EXP_WIDTH+2)*(MMM_CYCLES+2) cycles after busy rises; en=0 freezes everything; MODEXP_EARLY_EXIT_EN ends LOOP at top set bit.
module modexp_seq_ctrl #(
  parameter int EXP_WIDTH  = 8,
  parameter int MMM_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp_in,
  output logic                 busy,
  output logic                 done,
  output logic                 eoc,
  output logic                 rst_mmm,
  output logic                 ld_a,
  output logic                 ld_r,
  output logic                 lock1,
  output logic                 lock2,
  output logic [1:0]           sel1,
  output logic                 sel2
);
  localparam int STEP_LEN = MMM_CYCLES + 2;
  localparam int SCW      = $clog2(STEP_LEN);
  localparam int BCW      = $clog2(EXP_WIDTH + 1);
  localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_LEN - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(EXP_WIDTH - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_LOOP = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [SCW-1:0]       step_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [EXP_WIDTH-1:0] exp_reg;
  logic [EXP_WIDTH-1:0] exp_shift;
  logic                 step_end;
  logic                 pre_exit;
  logic                 loop_exit;

  assign step_end  = (step_cnt == STEP_LAST);
  assign exp_shift = exp_reg >> 1;

`ifdef MODEXP_EARLY_EXIT_EN
  // Stop multiplying once no set bits remain above the current one.
  assign pre_exit  = (exp_reg == '0);
  assign loop_exit = (bit_cnt == BIT_LAST) || (exp_shift == '0);
`else
  assign pre_exit  = 1'b0;
  assign loop_exit = (bit_cnt == BIT_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PRE;
      ST_PRE:  if (step_end) state_nxt = pre_exit ? ST_POST : ST_LOOP;
      ST_LOOP: if (step_end && loop_exit) state_nxt = ST_POST;
      ST_POST: if (step_end) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      bit_cnt  <= '0;
      exp_reg  <= '0;
    end else if (en) begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          step_cnt <= '0;
          if (start) begin
            exp_reg <= exp_in;
            bit_cnt <= '0;
          end
        end
        ST_PRE, ST_LOOP, ST_POST: step_cnt <= step_end ? '0 : step_cnt + 1'b1;
        default: step_cnt <= '0;
      endcase
      if (state == ST_LOOP && step_end) begin
        exp_reg <= exp_shift;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rst_mmm = 1'b0;
    ld_a    = 1'b0;
    ld_r    = 1'b0;
    lock1   = 1'b0;
    lock2   = 1'b0;
    sel1    = 2'b00;
    sel2    = 1'b0;
    case (state)
      ST_PRE: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        ld_a    = (step_cnt == '0);
        ld_r    = step_end;
        lock1   = 1'b1;
        lock2   = 1'b1;
      end
      ST_LOOP: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        ld_a    = (step_cnt == '0);
        ld_r    = step_end;
        lock1   = exp_reg[0];
        lock2   = 1'b1;
        sel1    = 2'b01;
        sel2    = 1'b1;
      end
      ST_POST: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        ld_a    = (step_cnt == '0);
        ld_r    = step_end;
        lock1   = 1'b1;
        sel1    = 2'b10;
        sel2    = 1'b1;
      end
      ST_DONE: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign eoc = done;

endmodule

// File: tb/tb_modexp_seq_ctrl.sv
// Bench for modexp_seq_ctrl: default instance plus a 16-bit/18-cycle instance, both checked every cycle
// against a phase/step arithmetic model; directed runs pin latencies and lock1 patterns, then random traffic.
module tb_modexp_seq_ctrl;
`ifdef MODEXP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb;
  logic        en;
  logic        start;
  logic [7:0]  exp_a;
  logic [15:0] exp_b;

  logic        busy_a, done_a, eoc_a, rst_mmm_a, ld_a_a, ld_r_a, lock1_a, lock2_a, sel2_a;
  logic [1:0]  sel1_a;
  logic        busy_b, done_b, eoc_b, rst_mmm_b, ld_a_b, ld_r_b, lock1_b, lock2_b, sel2_b;
  logic [1:0]  sel1_b;

  always #5 clk = ~clk;

  modexp_seq_ctrl #(.EXP_WIDTH(8), .MMM_CYCLES(10)) dut_a (
    .clk(clk), .rstb(rstb), .en(en), .start(start), .exp_in(exp_a),
    .busy(busy_a), .done(done_a), .eoc(eoc_a), .rst_mmm(rst_mmm_a),
    .ld_a(ld_a_a), .ld_r(ld_r_a), .lock1(lock1_a), .lock2(lock2_a),
    .sel1(sel1_a), .sel2(sel2_a)
  );

  modexp_seq_ctrl #(.EXP_WIDTH(16), .MMM_CYCLES(18)) dut_b (
    .clk(clk), .rstb(rstb), .en(en), .start(start), .exp_in(exp_b),
    .busy(busy_b), .done(done_b), .eoc(eoc_b), .rst_mmm(rst_mmm_b),
    .ld_a(ld_a_b), .ld_r(ld_r_b), .lock1(lock1_b), .lock2(lock2_b),
    .sel1(sel1_b), .sel2(sel2_b)
  );

  // Vector layout: busy done eoc rst_mmm ld_a ld_r lock1 lock2 sel1[1:0] sel2
  logic [10:0] act [2];
  assign act[0] = {busy_a, done_a, eoc_a, rst_mmm_a, ld_a_a, ld_r_a, lock1_a, lock2_a, sel1_a, sel2_a};
  assign act[1] = {busy_b, done_b, eoc_b, rst_mmm_b, ld_a_b, ld_r_b, lock1_b, lock2_b, sel1_b, sel2_b};

  int vectors = 0;
  int miscompares = 0;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int step_len(input int i);
    return (i == 0) ? 12 : 20;
  endfunction

  function automatic int loop_steps(input logic [15:0] e, input int w);
    int k;
    k = 0;
    if (!EARLY) return w;
    for (int b = 0; b < w; b++) if (e[b]) k = b + 1;
    return k;
  endfunction

  function automatic int total_cycles(input logic [15:0] e, input int i);
    return (loop_steps(e, wid(i)) + 2) * step_len(i);
  endfunction

  // Model: an active run is just a count of enabled cycles since busy rose.
  bit          m_active [2];
  int          m_n      [2];
  logic [15:0] m_e      [2];

  always @(posedge clk or negedge rstb) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstb) begin
        m_active[i] = 1'b0;
        m_n[i]      = 0;
      end else if (en) begin
        if (!m_active[i]) begin
          if (start) begin
            m_active[i] = 1'b1;
            m_n[i]      = 0;
            m_e[i]      = (i == 0) ? {8'h00, exp_a} : exp_b;
          end
        end else if (m_n[i] == total_cycles(m_e[i], i)) begin
          m_active[i] = 1'b0;
        end else begin
          m_n[i] = m_n[i] + 1;
        end
      end
    end
  end

  function automatic logic [10:0] model_vec(input int i);
    logic [10:0] v;
    int l, ns, ph, s;
    v = '0;
    if (m_active[i]) begin
      l  = step_len(i);
      ns = loop_steps(m_e[i], wid(i));
      v[10] = 1'b1;
      v[7]  = 1'b1;
      if (m_n[i] == (ns + 2) * l) begin
        v[9] = 1'b1;
        v[8] = 1'b1;
      end else begin
        ph = m_n[i] / l;
        s  = m_n[i] % l;
        v[6] = (s == 0);
        v[5] = (s == l - 1);
        if (ph == 0) begin
          v[4] = 1'b1; v[3] = 1'b1; v[2:1] = 2'b00; v[0] = 1'b0;
        end else if (ph <= ns) begin
          v[4] = m_e[i][ph-1]; v[3] = 1'b1; v[2:1] = 2'b01; v[0] = 1'b1;
        end else begin
          v[4] = 1'b1; v[3] = 1'b0; v[2:1] = 2'b10; v[0] = 1'b1;
        end
      end
    end
    return v;
  endfunction

  // Per-run observations, restarted whenever busy rises.
  int          cyc [2], done_cyc [2], li [2], lda_loop [2], last_lda [2], last_ldr [2];
  logic [15:0] pat [2];
  bit          pb  [2];

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic observe();
    logic [10:0] v;
    for (int i = 0; i < 2; i++) begin
      v = act[i];
      vectors++;
      if (v !== model_vec(i)) begin
        miscompares++;
        $display("FAIL outputs dut%0d t=%0t: got %b expected %b", i, $time, v, model_vec(i));
      end
      if (v[10] && !pb[i]) begin
        cyc[i] = 0; done_cyc[i] = -1; li[i] = 0; lda_loop[i] = 0;
        last_lda[i] = -1; last_ldr[i] = -1; pat[i] = '0;
      end else if (v[10]) begin
        cyc[i]++;
      end
      pb[i] = v[10];
      if (v[9] && done_cyc[i] < 0) done_cyc[i] = cyc[i];
      if (v[6] && en) last_lda[i] = cyc[i];
      if (v[5] && en) last_ldr[i] = cyc[i];
      if (v[6] && en && v[2:1] == 2'b01) begin
        if (li[i] < 16) pat[i][li[i]] = v[4];
        li[i]++;
        lda_loop[i]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dir(input logic [7:0] ea, input logic [15:0] eb,
                         input int frz_at, input int frz_len, input bit noise);
    exp_a = ea;
    exp_b = eb;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 380; c++) begin
      en = !(c >= frz_at && c < frz_at + frz_len);
      if (noise) begin
        start = (c == 30 || c == 60);
        if (c == 30) exp_a = 8'hFF;
      end
      cycle();
    end
    en    = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    rstb  = 1'b0;
    en    = 1'b0;
    start = 1'b0;
    exp_a = '0;
    exp_b = '0;
    repeat (3) cycle();
    rstb = 1'b1;
    en   = 1'b1;
    repeat (3) cycle();

    // Reset in the middle of PRE clears outputs without waiting for a clock edge.
    exp_a = 8'hA5;
    exp_b = 16'h1234;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    rstb = 1'b0;
    #1;
    chk("reset_immediate_a", act[0], 0);
    chk("reset_immediate_b", act[1], 0);
    repeat (2) cycle();
    rstb = 1'b1;
    repeat (5) cycle();

    run_dir(8'hA5, 16'h8001, 1000, 0, 1'b0);
    chk("a5_done_cycle", done_cyc[0], 120);
    chk("a5_lock1_pattern", pat[0], 16'h00A5);
    chk("a5_loop_steps", lda_loop[0], 8);
    chk("a5_last_ld_a", last_lda[0], 108);
    chk("a5_last_ld_r", last_ldr[0], 119);
    chk("w16_done_cycle", done_cyc[1], 360);
    chk("w16_lock1_pattern", pat[1], 16'h8001);
    chk("w16_loop_steps", lda_loop[1], 16);

    run_dir(8'hA5, 16'h0007, 40, 5, 1'b0);
    chk("freeze_done_cycle", done_cyc[0], 125);
    chk("freeze_lock1_pattern", pat[0], 16'h00A5);

    run_dir(8'hA5, 16'h0100, 1000, 0, 1'b1);
    chk("ignored_start_done_cycle", done_cyc[0], 120);
    chk("ignored_start_lock1_pattern", pat[0], 16'h00A5);

    run_dir(8'h03, 16'h0000, 1000, 0, 1'b0);
    chk("exp03_done_cycle", done_cyc[0], EARLY ? 48 : 120);
    chk("exp03_lock1_pattern", pat[0], 16'h0003);
    chk("exp03_loop_steps", lda_loop[0], EARLY ? 2 : 8);

    run_dir(8'h00, 16'h0000, 1000, 0, 1'b0);
    chk("exp00_done_cycle", done_cyc[0], EARLY ? 24 : 120);
    chk("exp00_loop_steps", lda_loop[0], EARLY ? 0 : 8);
    chk("exp00_w16_done_cycle", done_cyc[1], EARLY ? 40 : 360);

    for (int c = 0; c < 4000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 7) == 0);
      exp_a = 8'($urandom >> $urandom_range(24, 31));
      exp_b = 16'($urandom >> $urandom_range(16, 31));
      rstb  = ($urandom_range(0, 599) != 0);
      cycle();
    end
    rstb = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
